pwm_capture_unit: RTL and testbench

Input-capture block that measures an external PWM waveform on pin icp. It is the read side of the timer/PWM generator.
- Reports the period and the active-phase width in prescaled timer ticks, through capture registers and status flags.
- Sits beside the timer unit in the peripheral space.
- Control comes from a memory-mapped register with an AVR-style layout.

---
 rtl/pwm_capture_unit_pkg.sv | 44 ++++
 rtl/pwm_capture_unit_icp.sv | 45 ++++
 rtl/pwm_capture_unit.sv | 140 ++++++++++++++
 tb/tb_pwm_capture_unit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_capture_unit_pkg.sv
// Shared definitions for the PWM capture unit: clock-select codes, FSM
// encodings, control register bit positions and the prescaler tick decode.
package pwm_capture_unit_pkg;

  typedef enum logic [2:0] {
    STOPPED    = 3'd0,
    DIV1       = 3'd1,
    DIV8       = 3'd2,
    DIV64      = 3'd3,
    DIV256     = 3'd4,
    DIV1024    = 3'd5
  } cs_e;

  typedef enum logic [1:0] {
    CAP_IDLE   = 2'd0,
    CAP_ACTIVE = 2'd1,
    CAP_REST   = 2'd2
  } cap_state_e;

  localparam int ICNC_BIT = 7;
  localparam int ICES_BIT = 6;
  localparam int CS_MSB   = 2;
  localparam int CS_LSB   = 0;

  // Codes 0, 6 and 7 never tick; the top level also uses this to park the FSM.
  function automatic logic prescale_tick(input logic [2:0] cs, input logic [9:0] pre);
    logic t;
    t = 1'b0;
    case (cs)
      DIV1:    t = 1'b1;
      DIV8:    t = &pre[2:0];
      DIV64:   t = &pre[5:0];
      DIV256:  t = &pre[7:0];
      DIV1024: t = &pre[9:0];
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  function automatic logic cs_running(input logic [2:0] cs);
    return (cs != 3'd0) && (cs < 3'd6);
  endfunction

endpackage

// File: rtl/pwm_capture_unit_icp.sv
// Capture pin conditioning: two-flop synchronizer, optional majority-free
// noise canceler (all-equal history) and start/opposite edge detection.
module icp_conditioner
  import pwm_capture_unit_pkg::*;
#(
  parameter int NC_DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic icp,
  input  logic icnc,
  input  logic ices,
  output logic start_edge,
  output logic opp_edge
);

  logic sync1, sync2, filt, filt_d, edge_seen;
  logic [NC_DEPTH-1:0] hist;

  // Unfiltered and filtered paths differ only by the history depth, so both
  // edge polarities see the same latency within a given mode.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      hist   <= '0;
      filt   <= 1'b0;
      filt_d <= 1'b0;
    end else begin
      sync1  <= icp;
      sync2  <= sync1;
      hist   <= {hist[NC_DEPTH-2:0], sync2};
      if (!icnc)
        filt <= sync2;
      else if ((&hist) || (~|hist))
        filt <= hist[0];
      filt_d <= filt;
    end
  end

  assign edge_seen  = filt ^ filt_d;
  assign start_edge = edge_seen & (filt == ices);
  assign opp_edge   = edge_seen & (filt != ices);

endmodule

// File: rtl/pwm_capture_unit.sv
// PWM input capture: prescaler, measurement FSM, tick counter, capture
// registers and sticky status flags around the pin conditioner.
module pwm_capture_unit
  import pwm_capture_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16,
  parameter int NC_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  icp,
  input  logic [DATA_WIDTH-1:0] mem_ctrl,
  input  logic [1:0]            clr_flags,
  output logic [CNT_WIDTH-1:0]  period,
  output logic [CNT_WIDTH-1:0]  active,
  output logic                  capf,
  output logic                  ovf,
  output logic                  cap_strobe
);

  logic                 icnc, ices, ices_q;
  logic [2:0]           cs, cs_q;
  logic [9:0]           pre;
  logic                 tick, running, cfg_change, cnt_full;
  logic                 start_edge, opp_edge;
  logic                 capture, act_load, ovf_set;
  logic [CNT_WIDTH-1:0] cnt, cnt_next, cnt_inc, act_lat;
  logic                 unused_ctrl_bits;
  cap_state_e           state, state_next;

  assign icnc             = mem_ctrl[ICNC_BIT];
  assign ices             = mem_ctrl[ICES_BIT];
  assign cs               = mem_ctrl[CS_MSB:CS_LSB];
  assign unused_ctrl_bits = ^mem_ctrl[5:3];

  assign tick       = prescale_tick(cs, pre);
  assign running    = cs_running(cs);
  assign cfg_change = (ices != ices_q) || (cs != cs_q);
  assign cnt_full   = &cnt;
  assign cnt_inc    = cnt + {{(CNT_WIDTH-1){1'b0}}, tick};

  icp_conditioner #(.NC_DEPTH(NC_DEPTH)) u_cond (
    .clk        (clk),
    .reset      (reset),
    .icp        (icp),
    .icnc       (icnc),
    .ices       (ices),
    .start_edge (start_edge),
    .opp_edge   (opp_edge)
  );

  // Overflow wins over a coincident edge: the wrapped count would be garbage.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    capture    = 1'b0;
    act_load   = 1'b0;
    ovf_set    = 1'b0;
    if (!running || cfg_change) begin
      state_next = CAP_IDLE;
      cnt_next   = '0;
    end else begin
      case (state)
        CAP_IDLE: begin
          if (start_edge) begin
            state_next = CAP_ACTIVE;
            cnt_next   = '0;
          end
        end
        CAP_ACTIVE: begin
          cnt_next = cnt_inc;
          if (cnt_full && tick) begin
            ovf_set    = 1'b1;
            state_next = CAP_IDLE;
            cnt_next   = '0;
          end else if (opp_edge) begin
            act_load   = 1'b1;
            state_next = CAP_REST;
          end
        end
        CAP_REST: begin
          cnt_next = cnt_inc;
          if (cnt_full && tick) begin
            ovf_set    = 1'b1;
            state_next = CAP_IDLE;
            cnt_next   = '0;
          end else if (start_edge) begin
            capture    = 1'b1;
            state_next = CAP_ACTIVE;
            cnt_next   = '0;
          end
        end
        default: begin
          state_next = CAP_IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre        <= '0;
      ices_q     <= 1'b0;
      cs_q       <= '0;
      state      <= CAP_IDLE;
      cnt        <= '0;
      act_lat    <= '0;
      period     <= '0;
      active     <= '0;
      capf       <= 1'b0;
      ovf        <= 1'b0;
      cap_strobe <= 1'b0;
    end else begin
      pre        <= pre + 10'd1;
      ices_q     <= ices;
      cs_q       <= cs;
      state      <= state_next;
      cnt        <= cnt_next;
      cap_strobe <= capture;
      if (act_load)
        act_lat <= cnt_inc;
      if (capture) begin
        period <= cnt_inc;
        active <= act_lat;
      end
      // A flag being set this cycle beats a clear pulse arriving with it.
      if (capture)
        capf <= 1'b1;
      else if (clr_flags[0])
        capf <= 1'b0;
      if (ovf_set)
        ovf <= 1'b1;
      else if (clr_flags[1])
        ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pwm_capture_unit.sv
// Directed bench for pwm_capture_unit: expected captures are queued as the
// pin waveform is driven and checked whenever cap_strobe fires.
module tb_pwm_capture_unit;

  logic        clk;
  logic        reset;
  logic        icp;
  logic [7:0]  mem_ctrl;
  logic [1:0]  clr_flags;
  logic [15:0] period;
  logic [15:0] active;
  logic        capf;
  logic        ovf;
  logic        cap_strobe;

  int checks = 0;
  int errors = 0;
  int strobe_count = 0;
  int strobes_before;
  logic [31:0] exp_q[$];

  pwm_capture_unit dut (
    .clk        (clk),
    .reset      (reset),
    .icp        (icp),
    .mem_ctrl   (mem_ctrl),
    .clr_flags  (clr_flags),
    .period     (period),
    .active     (active),
    .capf       (capf),
    .ovf        (ovf),
    .cap_strobe (cap_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed no finish, required finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Holds icp at a level for n clocks; always entered and left on a falling edge.
  task automatic applyStimulus(input logic lvl, input int n);
    icp = lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic pushExp(input logic [15:0] p, input logic [15:0] a);
    exp_q.push_back({p, a});
  endtask

  task automatic drainCheck(input string tag);
    repeat (12) @(negedge clk);
    checkOutput(tag, exp_q.size(), 0);
  endtask

  // Scoreboard side: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (cap_strobe === 1'b1) begin
      logic [31:0] e;
      strobe_count++;
      checks++;
      assert (exp_q.size() > 0)
      else begin
        errors++;
        $error("[TB] FAIL unexpected_strobe: observed period %0d active %0d, expected no capture", period, active);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("cap_period", period, e[31:16]);
        checkOutput("cap_active", active, e[15:0]);
        checkOutput("cap_capf", capf, 1);
      end
    end
  end

  initial begin
    reset     = 1'b1;
    icp       = 1'b0;
    mem_ctrl  = 8'h41;
    clr_flags = 2'b00;
    repeat (3) @(negedge clk);
    checkOutput("rst_period", period, 0);
    checkOutput("rst_active", active, 0);
    checkOutput("rst_capf", capf, 0);
    checkOutput("rst_ovf", ovf, 0);
    checkOutput("rst_strobe", cap_strobe, 0);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    $display("[TB] div1 rising-start 30/70");
    strobes_before = strobe_count;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) pushExp(16'd100, 16'd30);
      applyStimulus(1'b1, 30);
      applyStimulus(1'b0, 70);
    end
    drainCheck("t1_pending");
    checkOutput("t1_strobes", strobe_count - strobes_before, 3);
    checkOutput("t1_capf", capf, 1);

    $display("[TB] div8 80/160");
    mem_ctrl = 8'h42;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) pushExp(16'd30, 16'd10);
      applyStimulus(1'b1, 80);
      applyStimulus(1'b0, 160);
    end
    drainCheck("t2_pending");

    $display("[TB] noise canceler swallows glitch");
    mem_ctrl = 8'hC1;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) pushExp(16'd100, 16'd30);
      applyStimulus(1'b1, 10);
      applyStimulus(1'b0, 2);
      applyStimulus(1'b1, 18);
      applyStimulus(1'b0, 70);
    end
    drainCheck("t3_nc_pending");

    $display("[TB] glitch passes without canceler");
    mem_ctrl = 8'h40;
    repeat (4) @(negedge clk);
    mem_ctrl = 8'h41;
    repeat (10) @(negedge clk);
    applyStimulus(1'b1, 10);
    pushExp(16'd12, 16'd10);
    applyStimulus(1'b0, 2);
    applyStimulus(1'b1, 18);
    applyStimulus(1'b0, 70);
    pushExp(16'd88, 16'd18);
    applyStimulus(1'b1, 30);
    applyStimulus(1'b0, 70);
    pushExp(16'd100, 16'd30);
    applyStimulus(1'b1, 30);
    applyStimulus(1'b0, 70);
    drainCheck("t3_raw_pending");

    $display("[TB] counter overflow");
    clr_flags = 2'b01;
    @(negedge clk);
    clr_flags = 2'b00;
    checkOutput("t4_capf_clr", capf, 0);
    mem_ctrl = 8'h40;
    repeat (4) @(negedge clk);
    mem_ctrl = 8'h41;
    repeat (10) @(negedge clk);
    icp = 1'b1;
    repeat (65539) @(negedge clk);
    checkOutput("t4_ovf_before", ovf, 0);
    clr_flags = 2'b10;
    @(negedge clk);
    clr_flags = 2'b00;
    checkOutput("t4_ovf_set_wins", ovf, 1);
    checkOutput("t4_capf", capf, 0);
    checkOutput("t4_period_kept", period, 100);
    checkOutput("t4_active_kept", active, 30);
    repeat (5) @(negedge clk);
    checkOutput("t4_ovf_sticky", ovf, 1);
    clr_flags = 2'b10;
    @(negedge clk);
    clr_flags = 2'b00;
    checkOutput("t4_ovf_cleared", ovf, 0);
    repeat (4450) @(negedge clk);
    applyStimulus(1'b0, 50);
    drainCheck("t4_pending");

    $display("[TB] ICES toggle aborts, falling-start 25/75");
    strobes_before = strobe_count;
    applyStimulus(1'b1, 10);
    mem_ctrl = 8'h01;
    repeat (20) @(negedge clk);
    applyStimulus(1'b0, 25);
    applyStimulus(1'b1, 75);
    checkOutput("t5_no_capture_yet", strobe_count - strobes_before, 0);
    for (int i = 0; i < 2; i++) begin
      pushExp(16'd100, 16'd25);
      applyStimulus(1'b0, 25);
      applyStimulus(1'b1, 75);
    end
    drainCheck("t6_pending");

    $display("[TB] stopped clock select");
    strobes_before = strobe_count;
    mem_ctrl = 8'h00;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 25);
      applyStimulus(1'b1, 75);
    end
    drainCheck("t5_cs0_pending");
    checkOutput("t5_cs0_strobes", strobe_count - strobes_before, 0);

    $display("[TB] reset mid-measurement");
    mem_ctrl = 8'h01;
    repeat (10) @(negedge clk);
    applyStimulus(1'b0, 25);
    applyStimulus(1'b1, 20);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("t6_rst_period", period, 0);
    checkOutput("t6_rst_active", active, 0);
    checkOutput("t6_rst_capf", capf, 0);
    checkOutput("t6_rst_ovf", ovf, 0);
    checkOutput("t6_rst_strobe", cap_strobe, 0);
    reset = 1'b0;
    repeat (55) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) pushExp(16'd100, 16'd25);
      applyStimulus(1'b0, 25);
      applyStimulus(1'b1, 75);
    end
    drainCheck("t6_after_rst_pending");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
